frame_strobe_sequencer: RTL and testbench



---
 rtl/frame_cfg_pkg.sv | 10 +
 rtl/frame_strobe_sequencer.sv | 86 ++++++++
 tb/tb_frame_strobe_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/frame_cfg_pkg.sv
// frame_cfg_pkg: shared state encoding and widths for column frame sequencing
package frame_cfg_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} fss_state_t;

    localparam int MAX_FRAMES  = 20;
    localparam int FRAME_IDX_W = $clog2(MAX_FRAMES);
    localparam int PHASE_CNT_W = 8;

endpackage

// File: rtl/frame_strobe_sequencer.sv
// frame_strobe_sequencer: writes one frame per request with setup/strobe/hold phasing
module frame_strobe_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = MAX_FRAMES,
    parameter int FrameBitsPerRow = 32,
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 1
) (
    input  logic                               CLK,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [$clog2(MaxFramesPerCol)-1:0] req_frame,
    input  logic [FrameBitsPerRow-1:0]         req_data,
    input  logic                               err_clr,
    output logic [FrameBitsPerRow-1:0]         FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               busy,
    output logic                               err,
    output logic [15:0]                        frame_count
);

    localparam int IdxW = $clog2(MaxFramesPerCol);
    localparam logic [IdxW:0] IDX_LIMIT = (IdxW + 1)'(MaxFramesPerCol);
    localparam logic [PHASE_CNT_W-1:0] S_LAST = PHASE_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [PHASE_CNT_W-1:0] T_LAST = PHASE_CNT_W'(STROBE_CYCLES - 1);
    localparam logic [PHASE_CNT_W-1:0] H_LAST = PHASE_CNT_W'(HOLD_CYCLES - 1);

    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255 || STROBE_CYCLES < 1 || STROBE_CYCLES > 255 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_phase
        $error("SETUP/STROBE/HOLD cycle counts must lie in 1..255");
    end

    fss_state_t state, state_n;
    logic [PHASE_CNT_W-1:0] phase, phase_n;
    logic [IdxW-1:0] idx;
    logic [FrameBitsPerRow-1:0] data;
    logic accept, in_range, last, done;

    always_comb begin
        accept   = req_valid && state == IDLE;
        in_range = {1'b0, req_frame} < IDX_LIMIT;
        last     = phase == (state == SETUP ? S_LAST : state == STROBE ? T_LAST : H_LAST);
        done     = state == HOLD && last;
        state_n  = state;
        phase_n  = last ? '0 : phase + 1'b1;
        case (state)
            IDLE: begin
                state_n = accept && in_range ? SETUP : IDLE;
                phase_n = '0;
            end
            SETUP:   state_n = last ? STROBE : SETUP;
            STROBE:  state_n = last ? HOLD : STROBE;
            default: state_n = last ? IDLE : HOLD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            idx         <= '0;
            data        <= '0;
            err         <= 1'b0;
            frame_count <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            if (accept) begin
                idx  <= req_frame;
                data <= req_data;
            end
            err <= (accept && !in_range) || (err && !err_clr);
            if (done && frame_count != 16'hFFFF)
                frame_count <= frame_count + 16'd1;
        end
    end

    assign req_ready   = state == IDLE;
    assign busy        = state != IDLE;
    assign FrameData   = state == IDLE ? '0 : data;
    assign FrameStrobe = state == STROBE ? MaxFramesPerCol'(1) << idx : '0;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// tb_frame_strobe_sequencer: directed vector bench for frame_strobe_sequencer
module tb_frame_strobe_sequencer;

    typedef struct {
        logic        rst, vld, clr;
        logic [4:0]  frm;
        logic [31:0] dat;
        logic        rdy, bsy, er;
        logic [31:0] fd;
        logic [19:0] fs;
        logic [15:0] fc;
    } vec_t;

    logic        CLK = 1'b0;
    logic        reset, req_valid, req_valid2, err_clr;
    logic [4:0]  req_frame;
    logic [31:0] req_data;
    logic        req_ready, busy, err, req_ready2, busy2, err2;
    logic [31:0] FrameData, FrameData2;
    logic [19:0] FrameStrobe, FrameStrobe2;
    logic [15:0] frame_count, frame_count2;
    int          total = 0;
    int          bad = 0;
    vec_t        v[$];

    always #5 CLK = ~CLK;

    frame_strobe_sequencer dut (
        .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_frame(req_frame), .req_data(req_data), .err_clr(err_clr),
        .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .err(err),
        .frame_count(frame_count)
    );

    frame_strobe_sequencer #(.SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2)) dut2 (
        .CLK(CLK), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_frame(req_frame), .req_data(req_data), .err_clr(err_clr),
        .FrameData(FrameData2), .FrameStrobe(FrameStrobe2), .busy(busy2), .err(err2),
        .frame_count(frame_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic vld, input logic clr, input logic [4:0] frm,
                       input logic [31:0] dat, input logic rdy, input logic bsy, input logic er,
                       input logic [31:0] fd, input logic [19:0] fs, input logic [15:0] fc);
        vec_t r;
        r.rst = rst; r.vld = vld; r.clr = clr; r.frm = frm; r.dat = dat;
        r.rdy = rdy; r.bsy = bsy; r.er = er; r.fd = fd; r.fs = fs; r.fc = fc;
        v.push_back(r);
    endtask

    initial begin
        // reset, then frame 5
        add(1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        20'h0,     16'd0);
        add(1'b0, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 20'h0,     16'd0);
        add(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 20'h00020, 16'd0);
        add(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 20'h00020, 16'd0);
        add(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 20'h0,     16'd0);
        add(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        20'h0,     16'd1);
        // out-of-range index, clear, set-wins, clear
        add(1'b0, 1'b1, 1'b0, 5'd20, 32'h12345678, 1'b1, 1'b0, 1'b1, 32'h0,        20'h0,     16'd1);
        add(1'b0, 1'b0, 1'b1, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        20'h0,     16'd1);
        add(1'b0, 1'b1, 1'b1, 5'd20, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        20'h0,     16'd1);
        add(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        20'h0,     16'd1);
        add(1'b0, 1'b0, 1'b1, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        20'h0,     16'd1);
        // back-to-back frames 0 then 19 with valid held
        add(1'b0, 1'b1, 1'b0, 5'd0,  32'h11111111, 1'b0, 1'b1, 1'b0, 32'h11111111, 20'h0,     16'd1);
        add(1'b0, 1'b1, 1'b0, 5'd19, 32'h22222222, 1'b0, 1'b1, 1'b0, 32'h11111111, 20'h00001, 16'd1);
        add(1'b0, 1'b1, 1'b0, 5'd19, 32'h22222222, 1'b0, 1'b1, 1'b0, 32'h11111111, 20'h00001, 16'd1);
        add(1'b0, 1'b1, 1'b0, 5'd19, 32'h22222222, 1'b0, 1'b1, 1'b0, 32'h11111111, 20'h0,     16'd1);
        add(1'b0, 1'b1, 1'b0, 5'd19, 32'h22222222, 1'b1, 1'b0, 1'b0, 32'h0,        20'h0,     16'd2);
        add(1'b0, 1'b1, 1'b0, 5'd19, 32'h22222222, 1'b0, 1'b1, 1'b0, 32'h22222222, 20'h0,     16'd2);
        add(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h22222222, 20'h80000, 16'd2);
        add(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h22222222, 20'h80000, 16'd2);
        add(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h22222222, 20'h0,     16'd2);
        add(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        20'h0,     16'd3);
        // reset in the middle of STROBE
        add(1'b0, 1'b1, 1'b0, 5'd7,  32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 20'h0,     16'd3);
        add(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 20'h00080, 16'd3);
        add(1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        20'h0,     16'd0);
        add(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        20'h0,     16'd0);

        req_valid2 = 1'b0;
        foreach (v[i]) begin
            reset = v[i].rst; req_valid = v[i].vld; err_clr = v[i].clr;
            req_frame = v[i].frm; req_data = v[i].dat;
            @(negedge CLK);
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(v[i].rdy));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(v[i].bsy));
            chk($sformatf("v%0d err", i), 32'(err), 32'(v[i].er));
            chk($sformatf("v%0d FrameData", i), FrameData, v[i].fd);
            chk($sformatf("v%0d FrameStrobe", i), 32'(FrameStrobe), 32'(v[i].fs));
            chk($sformatf("v%0d frame_count", i), 32'(frame_count), 32'(v[i].fc));
        end

        // saturation: preload the counter just below the ceiling
        reset = 1'b0; req_valid = 1'b0; err_clr = 1'b0;
        force dut.frame_count = 16'hFFFE;
        #1 release dut.frame_count;
        for (int n = 0; n < 3; n++) begin
            req_valid = 1'b1; req_frame = 5'd2; req_data = 32'(n);
            @(negedge CLK);
            req_valid = 1'b0;
            repeat (4) @(negedge CLK);
            chk($sformatf("sat frame %0d ready", n), 32'(req_ready), 32'd1);
            chk($sformatf("sat frame %0d frame_count", n), 32'(frame_count), 32'hFFFF);
        end

        // S=3 T=4 H=2 instance, frame 3
        req_valid2 = 1'b1; req_frame = 5'd3; req_data = 32'hCAFEF00D;
        @(negedge CLK);
        req_valid2 = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("p k=%0d FrameStrobe", k), 32'(FrameStrobe2), (k >= 4 && k <= 7) ? 32'h8 : 32'h0);
            chk($sformatf("p k=%0d req_ready", k), 32'(req_ready2), (k >= 10) ? 32'd1 : 32'd0);
            chk($sformatf("p k=%0d FrameData", k), FrameData2, (k <= 9) ? 32'hCAFEF00D : 32'h0);
            @(negedge CLK);
        end
        chk("p frame_count", 32'(frame_count2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
